// File: rtl/bin_mult_add_shift_pkg.sv
// Shared constants and the controller state type for the add-and-shift
// multiplier. Optional self-check macro: BIN_MULT_CHECK_EN.
package bin_mult_add_shift_pkg;

  localparam int dp_width = 5;
  localparam int bc_size  = $clog2(dp_width + 1);
  localparam int st_width = 1;

  typedef enum logic [st_width-1:0] {
    S_idle    = 1'b0,
    S_running = 1'b1
  } state_t;

endpackage

// File: rtl/bin_mult_add_shift_if.sv
// Start/ready handshake plus operand and product bus of the multiplier.
interface bin_mult_add_shift_if;
  import bin_mult_add_shift_pkg::*;

  logic                    start;
  logic [dp_width-1:0]     multiplicand;
  logic [dp_width-1:0]     multiplier;
  logic                    rdy;
  logic [2*dp_width-1:0]   product;

  modport master (
    output start, multiplicand, multiplier,
    input  rdy, product
  );

  modport slave (
    input  start, multiplicand, multiplier,
    output rdy, product
  );

endinterface

// File: rtl/bin_mult_add_shift_ctrl.sv
// Two-state controller: idle waits for start, running retires one
// multiplier bit per cycle until the bit counter reaches its last bit.
module bin_mult_add_shift_ctrl
  import bin_mult_add_shift_pkg::*;
(
  input  logic               clk,
  input  logic               rst_b,
  input  logic               start_i,
  input  logic               q0_i,
  input  logic [bc_size-1:0] p_i,
  output logic               rdy_o,
  output logic               load_regs_o,
  output logic               decr_p_o,
  output logic               add_shift_regs_o,
  output logic               shift_regs_o,
  output logic               zero_o
);

  state_t state_q, state_d;

  // State register; rst_b is active-high despite its name.
  always_ff @(posedge clk) begin
    if (rst_b) state_q <= S_idle;
    else       state_q <= state_d;
  end

  // Next-state logic and control decode.
  always_comb begin
    state_d          = state_q;
    load_regs_o      = 1'b0;
    decr_p_o         = 1'b0;
    add_shift_regs_o = 1'b0;
    shift_regs_o     = 1'b0;
    case (state_q)
      S_idle: begin
        if (start_i) begin
          load_regs_o = 1'b1;
          state_d     = S_running;
        end
      end
      S_running: begin
        decr_p_o         = 1'b1;
        add_shift_regs_o = q0_i;
        shift_regs_o     = ~q0_i;
        if (p_i == bc_size'(1)) state_d = S_idle;
      end
      default: state_d = S_idle;
    endcase
  end

  assign rdy_o  = (state_q == S_idle);
  assign zero_o = (p_i == '0);

endmodule

// File: rtl/bin_mult_add_shift.sv
// Sequential unsigned add-and-shift multiplier. Registers B (multiplicand),
// A/Q (product high/low, Q initially holds the multiplier), C (carry) and
// bit counter P. Defining BIN_MULT_CHECK_EN adds simulation self-checks.
module bin_mult_add_shift
  import bin_mult_add_shift_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_b,
  bin_mult_add_shift_if.slave   bus
);

  logic [dp_width-1:0] b_q, b_d;
  logic [dp_width-1:0] a_q, a_d;
  logic [dp_width-1:0] q_q, q_d;
  logic                c_q, c_d;
  logic [bc_size-1:0]  p_q, p_d;
  logic [dp_width:0]   ca_sum;

  logic rdy, load_regs, decr_p, add_shift_regs, shift_regs, zero;

  bin_mult_add_shift_ctrl u_ctrl (
    .clk              (clk),
    .rst_b            (rst_b),
    .start_i          (bus.start),
    .q0_i             (q_q[0]),
    .p_i              (p_q),
    .rdy_o            (rdy),
    .load_regs_o      (load_regs),
    .decr_p_o         (decr_p),
    .add_shift_regs_o (add_shift_regs),
    .shift_regs_o     (shift_regs),
    .zero_o           (zero)
  );

  // Datapath next state: load operands, or add-then-shift / shift in one step.
  always_comb begin
    b_d = b_q;
    a_d = a_q;
    q_d = q_q;
    c_d = c_q;
    p_d = p_q;
    // {C,A} before the shift: the widened sum when Q[0] is set, else unchanged.
    ca_sum = add_shift_regs ? ({1'b0, a_q} + {1'b0, b_q}) : {c_q, a_q};
    if (load_regs) begin
      b_d = bus.multiplicand;
      q_d = bus.multiplier;
      a_d = '0;
      c_d = 1'b0;
      p_d = bc_size'(dp_width);
    end else begin
      if (add_shift_regs || shift_regs) begin
        c_d = 1'b0;
        a_d = ca_sum[dp_width:1];
        q_d = {ca_sum[0], q_q[dp_width-1:1]};
      end
      // The zero guard keeps P from wrapping even if decode misbehaves.
      if (decr_p && !zero) p_d = p_q - bc_size'(1);
    end
  end

  // Datapath registers; reset clears everything so product reads 0.
  always_ff @(posedge clk) begin
    if (rst_b) begin
      b_q <= '0;
      a_q <= '0;
      q_q <= '0;
      c_q <= 1'b0;
      p_q <= '0;
    end else begin
      b_q <= b_d;
      a_q <= a_d;
      q_q <= q_d;
      c_q <= c_d;
      p_q <= p_d;
    end
  end

  assign bus.rdy     = rdy;
  assign bus.product = {a_q, q_q};

`ifdef BIN_MULT_CHECK_EN
  logic [dp_width-1:0] chk_mc_q, chk_mp_q;
  logic                chk_pend_q;

  // Operand shadow copies and end-of-run product / counter checks.
  always_ff @(posedge clk) begin
    if (rst_b) begin
      chk_pend_q <= 1'b0;
      chk_mc_q   <= '0;
      chk_mp_q   <= '0;
    end else begin
      if (load_regs) begin
        chk_mc_q <= bus.multiplicand;
        chk_mp_q <= bus.multiplier;
      end
      chk_pend_q <= decr_p && (p_q == bc_size'(1));
      if (chk_pend_q) begin
        assert ({a_q, q_q} == ((2*dp_width)'(chk_mc_q) * (2*dp_width)'(chk_mp_q)))
          else $error("product %0d != %0d * %0d", {a_q, q_q}, chk_mc_q, chk_mp_q);
      end
      assert (!(decr_p && zero))
        else $error("bit counter decremented from zero");
    end
  end
`endif

endmodule

// File: tb/tb_bin_mult_add_shift.sv
// Self-checking bench for the add-and-shift multiplier: directed table,
// exhaustive back-to-back sweep, randomized runs and a mid-run reset.
module tb_bin_mult_add_shift;
  import bin_mult_add_shift_pkg::*;

  typedef struct {
    int mc;
    int mp;
    int exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_b;
  int   n_vec = 0;
  int   n_bad = 0;

  bin_mult_add_shift_if bus();

  bin_mult_add_shift dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Count falling edges until rdy is seen high (bounded).
  task automatic wait_rdy(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (bus.rdy !== 1'b1 && cyc < 50);
  endtask

  // Single pulsed-start multiply; returns product and edges until rdy.
  task automatic do_mult(input int mc, input int mp, output int prod, output int cyc);
    @(negedge clk);
    bus.start        = 1'b1;
    bus.multiplicand = dp_width'(mc);
    bus.multiplier   = dp_width'(mp);
    cyc = 0;
    do begin
      @(negedge clk);
      bus.start = 1'b0;
      cyc++;
    end while (bus.rdy !== 1'b1 && cyc < 50);
    prod = int'(bus.product);
  endtask

  initial begin
    vec_t tbl[8];
    int prod, cyc, mc, mp, exp;

    tbl[0] = '{5, 3, 15};
    tbl[1] = '{31, 31, 961};
    tbl[2] = '{17, 0, 0};
    tbl[3] = '{31, 1, 31};
    tbl[4] = '{0, 31, 0};
    tbl[5] = '{1, 1, 1};
    tbl[6] = '{16, 16, 256};
    tbl[7] = '{21, 10, 210};

    rst_b            = 1'b1;
    bus.start        = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier   = '0;

    // Reset state
    @(negedge clk);
    chk("reset_rdy", int'(bus.rdy), 1);
    chk("reset_product", int'(bus.product), 0);
    rst_b = 1'b0;

    // Directed table
    for (int i = 0; i < 8; i++) begin
      do_mult(tbl[i].mc, tbl[i].mp, prod, cyc);
      chk($sformatf("tbl%0d_latency", i), cyc, dp_width + 1);
      chk($sformatf("tbl%0d_product", i), prod, tbl[i].exp);
      if (i == 0) begin
        repeat (3) @(negedge clk);
        chk("hold_rdy", int'(bus.rdy), 1);
        chk("hold_product", int'(bus.product), 15);
      end
    end

    // Exhaustive sweep with start held high, operands changed at each rdy
    @(negedge clk);
    bus.start        = 1'b1;
    bus.multiplicand = '0;
    bus.multiplier   = '0;
    for (int i = 0; i < 1024; i++) begin
      wait_rdy(cyc);
      exp = (i >> 5) * (i & 31);
      n_vec++;
      if (int'(bus.product) != exp || cyc != dp_width + 1) begin
        n_bad++;
        $display("FAIL sweep %0d*%0d: got %0d after %0d edges, required %0d after %0d",
                 i >> 5, i & 31, bus.product, cyc, exp, dp_width + 1);
      end
      if (i < 1023) begin
        bus.multiplicand = dp_width'((i + 1) >> 5);
        bus.multiplier   = dp_width'((i + 1) & 31);
      end else begin
        bus.start = 1'b0;
      end
    end
    @(negedge clk);

    // Randomized runs: operands and start scrambled while running
    for (int r = 0; r < 40; r++) begin
      repeat ($urandom_range(2, 0)) @(negedge clk);
      mc = int'($urandom_range(31, 0));
      mp = int'($urandom_range(31, 0));
      exp = mc * mp;
      @(negedge clk);
      bus.start        = 1'b1;
      bus.multiplicand = dp_width'(mc);
      bus.multiplier   = dp_width'(mp);
      cyc = 0;
      do begin
        @(negedge clk);
        cyc++;
        if (bus.rdy !== 1'b1) begin
          bus.start        = 1'($urandom_range(1, 0));
          bus.multiplicand = dp_width'($urandom_range(31, 0));
          bus.multiplier   = dp_width'($urandom_range(31, 0));
        end
      end while (bus.rdy !== 1'b1 && cyc < 50);
      bus.start = 1'b0;
      n_vec++;
      if (int'(bus.product) != exp || cyc != dp_width + 1) begin
        n_bad++;
        $display("FAIL random %0d*%0d: got %0d after %0d edges, required %0d after %0d",
                 mc, mp, bus.product, cyc, exp, dp_width + 1);
      end
    end

    // Reset during the third running cycle of 7*9
    @(negedge clk);
    bus.start        = 1'b1;
    bus.multiplicand = 5'd7;
    bus.multiplier   = 5'd9;
    @(negedge clk);
    bus.start = 1'b0;
    chk("abort_running", int'(bus.rdy), 0);
    @(negedge clk);
    @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    chk("abort_rdy", int'(bus.rdy), 1);
    chk("abort_product", int'(bus.product), 0);
    rst_b = 1'b0;
    do_mult(7, 9, prod, cyc);
    chk("after_abort_latency", cyc, dp_width + 1);
    chk("after_abort_product", prod, 63);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
